// File: rtl/mem_responder.sv
// Valid/ready memory target: latches one read or write per request and answers
// after WAIT_CYCLES wait states. Optional read parity via MEM_PARITY_EN.
module mem_responder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready
`ifdef MEM_PARITY_EN
    ,
    output logic                  perr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  mem_we_s;

`ifdef MEM_PARITY_EN
    logic mem_par [0:DEPTH-1];
    logic perr_q, perr_d;

    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state, request latching and response generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        mem_we_s = 1'b0;
`ifdef MEM_PARITY_EN
        perr_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // ready_q high means the previous answer is still visible; hold off.
                if (valid && !ready_q) begin
                    wr_d    = wr_rd;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!valid) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                mem_we_s = wr_q && !rst;
`ifdef MEM_PARITY_EN
                perr_d   = !wr_q && (even_par(mem[addr_q]) != mem_par[addr_q]);
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if ((state_d == S_RESP) && (state_q != S_RESP) && !wr_d) begin
            rdata_d = mem[addr_d];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef MEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef MEM_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[addr_q] <= wdata_q;
`ifdef MEM_PARITY_EN
            mem_par[addr_q] <= even_par(wdata_q);
`endif
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
`ifdef MEM_PARITY_EN
    assign perr  = perr_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: one instance with two wait states,
// one with none. Parity checks are compiled in when MEM_PARITY_EN is defined.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_a, wr_a, valid_b, wr_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic       ready_a, ready_b;
`ifdef MEM_PARITY_EN
    logic       perr_a, perr_b;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] model_a [16];
    logic [7:0] model_b [16];
    logic       mpar_a  [16];
    logic [7:0] last_rd_a, last_rd_b;
    logic [8:0] sb_q [$];

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(8), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .valid(valid_a), .wr_rd(wr_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a)
`ifdef MEM_PARITY_EN
        , .perr(perr_a)
`endif
    );

    mem_responder #(.WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .valid(valid_b), .wr_rd(wr_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b)
`ifdef MEM_PARITY_EN
        , .perr(perr_b)
`endif
    );

    // One transaction on instance sel (0 = W2, 1 = W0); called at a negedge.
    task automatic txn(input int sel, input logic wr, input logic [3:0] a, input logic [7:0] d);
        int         lat;
        int         exp_lat;
        logic       rdy;
        logic [7:0] rd;
        logic [8:0] exp;
        exp_lat = (sel == 0) ? 3 : 1;
        if (sel == 0) begin
            valid_a = 1'b1; wr_a = wr; addr_a = a; wdata_a = d;
            if (wr) begin
                model_a[a] = d;
                mpar_a[a]  = ^d;
            end else begin
                sb_q.push_back({((^model_a[a]) != mpar_a[a]), model_a[a]});
            end
        end else begin
            valid_b = 1'b1; wr_b = wr; addr_b = a; wdata_b = d;
            if (wr) begin
                model_b[a] = d;
            end else begin
                sb_q.push_back({1'b0, model_b[a]});
            end
        end
        @(posedge clk);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? ready_a : ready_b;
            if (rdy) begin
                lat = i;
                break;
            end
        end
        rd = (sel == 0) ? rdata_a : rdata_b;
        valid_a = 1'b0;
        valid_b = 1'b0;
        tests++;
        assert (lat === exp_lat) else begin
            fails++;
            $error("FAIL latency inst=%0d addr=%0d observed=%0d expected=%0d", sel, a, lat, exp_lat);
        end
        if (!wr && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            tests++;
            assert (rd === exp[7:0]) else begin
                fails++;
                $error("FAIL rdata inst=%0d addr=%0d observed=%h expected=%h", sel, a, rd, exp[7:0]);
            end
`ifdef MEM_PARITY_EN
            tests++;
            assert (((sel == 0) ? perr_a : perr_b) === exp[8]) else begin
                fails++;
                $error("FAIL perr inst=%0d addr=%0d observed=%b expected=%b", sel, a,
                       (sel == 0) ? perr_a : perr_b, exp[8]);
            end
`endif
            if (sel == 0) last_rd_a = exp[7:0]; else last_rd_b = exp[7:0];
        end else if (wr) begin
            tests++;
            assert (rd === ((sel == 0) ? last_rd_a : last_rd_b)) else begin
                fails++;
                $error("FAIL rdata_hold inst=%0d observed=%h expected=%h", sel, rd,
                       (sel == 0) ? last_rd_a : last_rd_b);
            end
        end
        @(negedge clk);
        rdy = (sel == 0) ? ready_a : ready_b;
        tests++;
        assert (rdy === 1'b0) else begin
            fails++;
            $error("FAIL ready_twice inst=%0d observed=%b expected=0", sel, rdy);
        end
    endtask

    initial begin
        logic       seen;
        logic [7:0] pat;
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 8'h00; model_b[i] = 8'h00; mpar_a[i] = 1'b0;
        end
        rst = 1'b1;
        valid_a = 1'b0; wr_a = 1'b0; addr_a = 4'd0; wdata_a = 8'h00;
        valid_b = 1'b0; wr_b = 1'b0; addr_b = 4'd0; wdata_b = 8'h00;
        last_rd_a = 8'h00; last_rd_b = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        assert ({ready_a, rdata_a, ready_b, rdata_b} === 18'd0) else begin
            fails++;
            $error("FAIL reset_state observed=%b/%h/%b/%h expected=0", ready_a, rdata_a, ready_b, rdata_b);
        end
`ifdef MEM_PARITY_EN
        tests++;
        assert ({perr_a, perr_b} === 2'b00) else begin
            fails++;
            $error("FAIL reset_perr observed=%b%b expected=00", perr_a, perr_b);
        end
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single write/read at the top address.
        txn(0, 1'b1, 4'd15, 8'hA5);
        txn(0, 1'b0, 4'd15, 8'h00);

        // Full-depth frontdoor.
        for (int i = 0; i < 16; i++) txn(0, 1'b1, 4'(i), 8'(100 + i));
        for (int i = 0; i < 16; i++) txn(0, 1'b0, 4'(i), 8'h00);

        // Backdoor load then frontdoor read-back.
        for (int i = 0; i < 16; i++) begin
            pat = 8'(i * 17) ^ 8'h3C;
            dut_a.mem[i] = pat;
            model_a[i]   = pat;
        end
        for (int i = 0; i < 16; i++) txn(0, 1'b0, 4'(i), 8'h00);

        // Frontdoor overwrite 5..14, then inspect the whole array.
        for (int i = 5; i < 15; i++) txn(0, 1'b1, 4'(i), 8'(8'hC0 + i));
        for (int i = 0; i < 16; i++) begin
            tests++;
            assert (dut_a.mem[i] === model_a[i]) else begin
                fails++;
                $error("FAIL dump addr=%0d observed=%h expected=%h", i, dut_a.mem[i], model_a[i]);
            end
        end

        // Abort: valid drops during WAIT on a write.
        valid_a = 1'b1; wr_a = 1'b1; addr_a = 4'd4; wdata_a = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready_a) seen = 1'b1;
        end
        tests++;
        assert (seen === 1'b0) else begin
            fails++;
            $error("FAIL abort_ready observed=%b expected=0", seen);
        end
        tests++;
        assert (dut_a.mem[4] === model_a[4]) else begin
            fails++;
            $error("FAIL abort_mem observed=%h expected=%h", dut_a.mem[4], model_a[4]);
        end
        txn(0, 1'b0, 4'd4, 8'h00);

        // Reset asserted during RESP of a write.
        valid_a = 1'b1; wr_a = 1'b1; addr_a = 4'd9; wdata_a = 8'h77;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        valid_a = 1'b0;
        @(negedge clk);
        tests++;
        assert ({ready_a, rdata_a} === 9'd0) else begin
            fails++;
            $error("FAIL rst_in_resp observed=%b/%h expected=0/00", ready_a, rdata_a);
        end
        rst = 1'b0;
        last_rd_a = 8'h00;
        last_rd_b = 8'h00;
        @(negedge clk);
        txn(0, 1'b0, 4'd9, 8'h00);

`ifdef MEM_PARITY_EN
        // Parity: clean word, then a stale backdoor word.
        txn(0, 1'b1, 4'd2, 8'h81);
        txn(0, 1'b0, 4'd2, 8'h00);
        txn(0, 1'b1, 4'd3, 8'h00);
        dut_a.mem[3] = 8'h01;
        model_a[3]   = 8'h01;
        txn(0, 1'b0, 4'd3, 8'h00);
`endif

        // Zero wait states.
        txn(1, 1'b1, 4'd7, 8'h5A);
        txn(1, 1'b0, 4'd7, 8'h00);
        txn(1, 1'b1, 4'd7, 8'hE1);
        txn(1, 1'b0, 4'd7, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
